approx_mult_err_monitor: RTL and testbench

- Downstream error-analysis stage for the 32-bit approximate Karatsuba multiplier.
- Consumes operand/product triples (A, B, P), computes the exact product internally and accumulates hardware error metrics over a programmable sample window:
  - error count
  - sum of error distance
  - maximum error distance
- Replaces offline CSV post-processing so approximation quality can be measured in-system.

---
 rtl/approx_mult_pkg.sv | 41 ++++
 rtl/err_distance.sv | 74 +++++++
 rtl/approx_mult_err_monitor.sv | 168 ++++++++++++++++
 tb/tb_approx_mult_err_monitor.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/approx_mult_pkg.sv
// approx_mult_pkg
// Shared definitions for the approximate-multiplier error monitor:
//   - DEFAULT_W  : default operand width of the multiplier under test
//   - state_t    : monitor FSM encoding (IDLE=0, RUN=1, DRAIN=2, DONE=3)
//   - sat_add    : unsigned saturating add on a wide carrier type
// Optional feature macro used by the users of this package: APPROX_ERR_BIAS_EN.
package approx_mult_pkg;

  localparam int DEFAULT_W = 32;

  // Carrier width for sat_add; every accumulator that uses it must fit below this.
  localparam int SAT_MAX_W = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Adds a and b and clamps the result to 2^width - 1.
  // Returns {overflow, result}; operands are zero-extended by the caller.
  function automatic logic [SAT_MAX_W:0] sat_add(
    input logic [SAT_MAX_W-1:0] a,
    input logic [SAT_MAX_W-1:0] b,
    input int                   width
  );
    logic [SAT_MAX_W:0] one;
    logic [SAT_MAX_W:0] sum;
    logic [SAT_MAX_W:0] lim;
    one = {{SAT_MAX_W{1'b0}}, 1'b1};
    sum = {1'b0, a} + {1'b0, b};
    lim = (one << width) - one;
    if (sum > lim) begin
      sat_add = {1'b1, lim[SAT_MAX_W-1:0]};
    end else begin
      sat_add = {1'b0, sum[SAT_MAX_W-1:0]};
    end
  endfunction

endpackage

// File: rtl/err_distance.sv
// err_distance
// Three-stage exact-multiply / absolute-difference path with a valid bit per stage.
//   S1: register A, B, P    S2: exact = A*B    S3: ed = |exact - P|
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               synchronous clear of all stage valids
//   in_valid/a/b/p      triple entering S1
//   out_valid, out_ed   S3 result
//   out_neg             (APPROX_ERR_BIAS_EN only) P was larger than the exact product
//   pipe_busy           any stage holds a valid triple
module err_distance
  import approx_mult_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  input  logic           in_valid,
  input  logic [W-1:0]   in_a,
  input  logic [W-1:0]   in_b,
  input  logic [2*W-1:0] in_p,
  output logic           out_valid,
  output logic [2*W-1:0] out_ed,
`ifdef APPROX_ERR_BIAS_EN
  output logic           out_neg,
`endif
  output logic           pipe_busy
);

  logic           s1_valid_reg, s2_valid_reg, s3_valid_reg;
  logic [W-1:0]   s1_a_reg, s1_b_reg;
  logic [2*W-1:0] s1_p_reg, s2_exact_reg, s2_p_reg, s3_ed_reg;

  // Only the valid bits are reset/flushed; data registers are don't-care when invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
      s3_valid_reg <= 1'b0;
    end else if (flush) begin
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
      s3_valid_reg <= 1'b0;
    end else begin
      s1_valid_reg <= in_valid;
      s2_valid_reg <= s1_valid_reg;
      s3_valid_reg <= s2_valid_reg;
    end
  end

  always_ff @(posedge clk) begin
    s1_a_reg     <= in_a;
    s1_b_reg     <= in_b;
    s1_p_reg     <= in_p;
    s2_exact_reg <= (2*W)'(s1_a_reg) * (2*W)'(s1_b_reg);
    s2_p_reg     <= s1_p_reg;
    s3_ed_reg    <= (s2_exact_reg >= s2_p_reg) ? (s2_exact_reg - s2_p_reg)
                                               : (s2_p_reg - s2_exact_reg);
  end

`ifdef APPROX_ERR_BIAS_EN
  logic s3_neg_reg;
  always_ff @(posedge clk) begin
    s3_neg_reg <= (s2_exact_reg < s2_p_reg);
  end
  assign out_neg = s3_neg_reg;
`endif

  assign out_valid = s3_valid_reg;
  assign out_ed    = s3_ed_reg;
  assign pipe_busy = s1_valid_reg | s2_valid_reg | s3_valid_reg;

endmodule

// File: rtl/approx_mult_err_monitor.sv
// approx_mult_err_monitor
// In-system error statistics for an approximate W x W multiplier over a sample window.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, n_samples      clear statistics and open a window of n_samples triples
//   in_valid, in_ready    triple handshake (in_ready only while the window is short)
//   in_a, in_b, in_p      operands and approximate product under test
//   busy, done            window open / draining; statistics final
//   err_cnt               samples with P != A*B
//   ed_sum, ed_max        saturating sum and maximum of |A*B - P|
//   sat                   sticky saturation flag
//   err_bias              (APPROX_ERR_BIAS_EN only) signed saturating sum of A*B - P
// Optional feature macro: APPROX_ERR_BIAS_EN.
module approx_mult_err_monitor
  import approx_mult_pkg::*;
#(
  parameter int W     = DEFAULT_W,
  parameter int CNT_W = 32,
  parameter int ACC_W = 2*W + 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] n_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [2*W-1:0]   in_p,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] err_cnt,
  output logic [ACC_W-1:0] ed_sum,
  output logic [2*W-1:0]   ed_max,
  output logic             sat
`ifdef APPROX_ERR_BIAS_EN
  ,
  output logic signed [ACC_W:0] err_bias
`endif
);

  state_t           state_reg;
  logic [CNT_W-1:0] n_reg, acc_cnt_reg, err_cnt_reg;
  logic [ACC_W-1:0] ed_sum_reg;
  logic [2*W-1:0]   ed_max_reg;
  logic             sat_reg;

  logic             xfer;
  logic             ed_valid, pipe_busy;
  logic [2*W-1:0]   ed;

  assign in_ready = (state_reg == RUN) && (acc_cnt_reg < n_reg);
  // A start in the same cycle wins over the handshake.
  assign xfer     = in_valid && in_ready && !start;

`ifdef APPROX_ERR_BIAS_EN
  logic ed_neg;
`endif

  err_distance #(.W(W)) u_err_distance (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (start),
    .in_valid  (xfer),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_p      (in_p),
    .out_valid (ed_valid),
    .out_ed    (ed),
`ifdef APPROX_ERR_BIAS_EN
    .out_neg   (ed_neg),
`endif
    .pipe_busy (pipe_busy)
  );

  logic [SAT_MAX_W:0] sum_res;
  logic               sum_unused;
  assign sum_res    = sat_add(SAT_MAX_W'(ed_sum_reg), SAT_MAX_W'(ed), ACC_W);
  // Bits above ACC_W are always zero after clamping.
  assign sum_unused = ^sum_res[SAT_MAX_W-1:ACC_W];

`ifdef APPROX_ERR_BIAS_EN
  localparam int BW = ACC_W + 1;
  logic signed [BW-1:0] err_bias_reg, bias_next;
  logic signed [BW:0]   bias_diff, bias_sum;
  logic                 bias_ovf;

  // One guard bit suffices: |A*B - P| < 2^(2W) <= 2^(BW-1).
  always_comb begin
    bias_diff = $signed({{(BW+1-2*W){1'b0}}, ed});
    if (ed_neg) begin
      bias_diff = -bias_diff;
    end
    bias_sum = {err_bias_reg[BW-1], err_bias_reg} + bias_diff;
    bias_ovf = (bias_sum[BW] != bias_sum[BW-1]);
    if (!bias_ovf) begin
      bias_next = bias_sum[BW-1:0];
    end else if (bias_sum[BW]) begin
      bias_next = {1'b1, {(BW-1){1'b0}}};
    end else begin
      bias_next = {1'b0, {(BW-1){1'b1}}};
    end
  end

  assign err_bias = err_bias_reg;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      n_reg       <= '0;
      acc_cnt_reg <= '0;
      err_cnt_reg <= '0;
      ed_sum_reg  <= '0;
      ed_max_reg  <= '0;
      sat_reg     <= 1'b0;
`ifdef APPROX_ERR_BIAS_EN
      err_bias_reg <= '0;
`endif
    end else if (start) begin
      n_reg       <= n_samples;
      acc_cnt_reg <= '0;
      err_cnt_reg <= '0;
      ed_sum_reg  <= '0;
      ed_max_reg  <= '0;
      sat_reg     <= 1'b0;
`ifdef APPROX_ERR_BIAS_EN
      err_bias_reg <= '0;
`endif
      state_reg   <= (n_samples == '0) ? DONE : RUN;
    end else begin
      if (xfer) begin
        acc_cnt_reg <= acc_cnt_reg + CNT_W'(1);
      end
      case (state_reg)
        RUN:     if (acc_cnt_reg == n_reg) state_reg <= DRAIN;
        DRAIN:   if (!pipe_busy) state_reg <= DONE;
        default: ;
      endcase
      if (ed_valid) begin
        if (ed != '0) begin
          err_cnt_reg <= err_cnt_reg + CNT_W'(1);
        end
        if (ed > ed_max_reg) begin
          ed_max_reg <= ed;
        end
        ed_sum_reg <= sum_res[ACC_W-1:0];
        if (sum_res[SAT_MAX_W]) begin
          sat_reg <= 1'b1;
        end
`ifdef APPROX_ERR_BIAS_EN
        err_bias_reg <= bias_next;
        if (bias_ovf) begin
          sat_reg <= 1'b1;
        end
`endif
      end
    end
  end

  assign busy    = (state_reg == RUN) || (state_reg == DRAIN);
  assign done    = (state_reg == DONE);
  assign err_cnt = err_cnt_reg;
  assign ed_sum  = ed_sum_reg;
  assign ed_max  = ed_max_reg;
  assign sat     = sat_reg;

endmodule

// File: tb/tb_approx_mult_err_monitor.sv
// Testbench for approx_mult_err_monitor. Two instances share all stimulus: the
// default accumulator width and a narrow one (ACC_W = 2W) that can saturate.
// A transaction-level model (list of accepted triples with acceptance cycle)
// predicts every output each cycle. Honours APPROX_ERR_BIAS_EN if defined.
`timescale 1ns/1ps
module tb_approx_mult_err_monitor;
  localparam int W      = 32;
  localparam int CNT_W  = 32;
  localparam int ACC1_W = 2*W + 16;
  localparam int ACC2_W = 2*W;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] n_samples = '0;
  logic             in_valid = 1'b0;
  logic [W-1:0]     in_a = '0, in_b = '0;
  logic [2*W-1:0]   in_p = '0;

  logic              d1_in_ready, d1_busy, d1_done, d1_sat;
  logic [CNT_W-1:0]  d1_err_cnt;
  logic [ACC1_W-1:0] d1_ed_sum;
  logic [2*W-1:0]    d1_ed_max;
  logic              d2_in_ready, d2_busy, d2_done, d2_sat;
  logic [CNT_W-1:0]  d2_err_cnt;
  logic [ACC2_W-1:0] d2_ed_sum;
  logic [2*W-1:0]    d2_ed_max;
`ifdef APPROX_ERR_BIAS_EN
  logic signed [ACC1_W:0] d1_err_bias;
  logic signed [ACC2_W:0] d2_err_bias;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  approx_mult_err_monitor #(.W(W), .CNT_W(CNT_W), .ACC_W(ACC1_W)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .n_samples(n_samples),
    .in_valid(in_valid), .in_ready(d1_in_ready), .in_a(in_a), .in_b(in_b), .in_p(in_p),
    .busy(d1_busy), .done(d1_done), .err_cnt(d1_err_cnt), .ed_sum(d1_ed_sum),
    .ed_max(d1_ed_max), .sat(d1_sat)
`ifdef APPROX_ERR_BIAS_EN
    , .err_bias(d1_err_bias)
`endif
  );

  approx_mult_err_monitor #(.W(W), .CNT_W(CNT_W), .ACC_W(ACC2_W)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .n_samples(n_samples),
    .in_valid(in_valid), .in_ready(d2_in_ready), .in_a(in_a), .in_b(in_b), .in_p(in_p),
    .busy(d2_busy), .done(d2_done), .err_cnt(d2_err_cnt), .ed_sum(d2_ed_sum),
    .ed_max(d2_ed_max), .sat(d2_sat)
`ifdef APPROX_ERR_BIAS_EN
    , .err_bias(d2_err_bias)
`endif
  );

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [2*W-1:0] ed;
    bit             neg;
    int             acc_cyc;
  } smp_t;

  smp_t            q[$];
  int              cyc = 0;
  bit              m_started = 1'b0;
  longint unsigned m_n = 0, m_acc = 0;
  int              m_last = 0;
  int              xfer_seen = 0;

  function automatic bit exp_ready();
    return m_started && (m_acc < m_n);
  endfunction

  function automatic bit exp_done();
    return m_started && (m_n == 0 || (m_acc == m_n && cyc >= m_last + 4));
  endfunction

  function automatic bit exp_busy();
    return m_started && (m_n != 0) && !exp_done();
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_started = 1'b0;
      m_n = 0;
      m_acc = 0;
      q.delete();
    end else begin
      cyc++;
      if (in_valid && d1_in_ready && !start) xfer_seen++;
      if (start) begin
        m_started = 1'b1;
        m_n = n_samples;
        m_acc = 0;
        q.delete();
      end else if (in_valid && exp_ready()) begin
        smp_t s;
        logic [2*W-1:0] ex;
        ex = (2*W)'(in_a) * (2*W)'(in_b);
        s.neg = (in_p > ex);
        s.ed = s.neg ? in_p - ex : ex - in_p;
        s.acc_cyc = cyc;
        q.push_back(s);
        m_acc++;
        m_last = cyc;
        $display("txn cyc=%0d a=%0d b=%0d p=%0d ed=%0d", cyc, in_a, in_b, in_p, s.ed);
      end
    end
  end

  // Statistics visible at cycle cyc: every accepted triple at least 3 edges old.
  task automatic exp_stats(input int acc_w, output longint unsigned ec,
                           output logic [127:0] sum, output logic [127:0] mx,
                           output bit st, output logic signed [127:0] bias);
    logic [127:0] lim, tot;
`ifdef APPROX_ERR_BIAS_EN
    logic signed [127:0] bmax, bmin, d;
`endif
    lim = (128'd1 << acc_w) - 128'd1;
    ec = 0; tot = '0; mx = '0; st = 1'b0; bias = '0;
`ifdef APPROX_ERR_BIAS_EN
    bmax = $signed(lim);
    bmin = -bmax - 128'sd1;
`endif
    foreach (q[i]) begin
      if (q[i].acc_cyc + 3 <= cyc) begin
        if (q[i].ed != '0) ec++;
        tot = tot + 128'(q[i].ed);
        if (128'(q[i].ed) > mx) mx = 128'(q[i].ed);
`ifdef APPROX_ERR_BIAS_EN
        d = $signed(128'(q[i].ed));
        if (q[i].neg) d = -d;
        bias = bias + d;
        if (bias > bmax) begin bias = bmax; st = 1'b1; end
        else if (bias < bmin) begin bias = bmin; st = 1'b1; end
`endif
      end
    end
    if (tot > lim) begin
      st = 1'b1;
      sum = lim;
    end else begin
      sum = tot;
    end
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  bit chk_en = 1'b0;

  always @(negedge clk) begin
    longint unsigned     ec;
    logic [127:0]        sm, mx;
    bit                  st;
    logic signed [127:0] bs;
    if (chk_en) begin
      chk("in_ready", d1_in_ready, exp_ready());
      chk("busy", d1_busy, exp_busy());
      chk("done", d1_done, exp_done());
      chk("d2_in_ready", d2_in_ready, exp_ready());
      chk("d2_done", d2_done, exp_done());
      chk("d2_busy", d2_busy, exp_busy());
      exp_stats(ACC1_W, ec, sm, mx, st, bs);
      chk("err_cnt", d1_err_cnt, ec);
      chk("ed_sum", d1_ed_sum, sm);
      chk("ed_max", d1_ed_max, mx);
      chk("sat", d1_sat, st);
`ifdef APPROX_ERR_BIAS_EN
      chk("err_bias", d1_err_bias, bs);
`endif
      exp_stats(ACC2_W, ec, sm, mx, st, bs);
      chk("d2_err_cnt", d2_err_cnt, ec);
      chk("d2_ed_sum", d2_ed_sum, sm);
      chk("d2_ed_max", d2_ed_max, mx);
      chk("d2_sat", d2_sat, st);
`ifdef APPROX_ERR_BIAS_EN
      chk("d2_err_bias", d2_err_bias, bs);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit st, input longint unsigned n, input bit v,
                       input logic [W-1:0] a, input logic [W-1:0] b, input logic [2*W-1:0] p);
    start = st;
    n_samples = CNT_W'(n);
    in_valid = v;
    in_a = a;
    in_b = b;
    in_p = p;
    @(posedge clk);
    #1;
    start = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int k);
    repeat (k) drive(1'b0, 0, 1'b0, '0, '0, '0);
  endtask

  task automatic wait_done(input string name, input int budget);
    int i;
    i = 0;
    while (!d1_done && i < budget) begin
      idle(1);
      i++;
    end
    chk(name, d1_done, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic [2*W-1:0] ex;
    logic [W-1:0] ra, rb;
    logic [2*W-1:0] rp;

    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_in_ready", d1_in_ready, 1'b0);
    chk("rst_busy", d1_busy, 1'b0);
    chk("rst_done", d1_done, 1'b0);
    chk("rst_err_cnt", d1_err_cnt, '0);
    chk("rst_ed_sum", d1_ed_sum, '0);
    idle(2);

    // exact stream
    drive(1'b1, 4, 1'b0, '0, '0, '0);
    repeat (4) drive(1'b0, 0, 1'b1, 32'd65536, 32'd18, 64'd1179648);
    wait_done("exact_done", 20);
    chk("exact_err_cnt", d1_err_cnt, 0);
    chk("exact_ed_sum", d1_ed_sum, 0);
    chk("exact_ed_max", d1_ed_max, 0);

    // mixed errors: 48584*54471 = 2646419064 exactly
    drive(1'b1, 3, 1'b0, '0, '0, '0);
    drive(1'b0, 0, 1'b1, 32'd48584, 32'd54471, 64'd2646419064);
    drive(1'b0, 0, 1'b1, 32'd10, 32'd10, 64'd90);
    drive(1'b0, 0, 1'b1, 32'd7, 32'd3, 64'd25);
    wait_done("mix_done", 20);
    chk("mix_err_cnt", d1_err_cnt, 2);
    chk("mix_ed_sum", d1_ed_sum, 14);
    chk("mix_ed_max", d1_ed_max, 10);
`ifdef APPROX_ERR_BIAS_EN
    chk("mix_err_bias", d1_err_bias, 6);   // +10 (exact 100 vs 90) and -4 (21 vs 25)
    drive(1'b1, 1, 1'b0, '0, '0, '0);
    drive(1'b0, 0, 1'b1, 32'd7, 32'd3, 64'd25);
    wait_done("bias_done", 20);
    chk("bias_neg4", d1_err_bias, -4);
`endif

    // window limit
    base = xfer_seen;
    drive(1'b1, 2, 1'b0, '0, '0, '0);
    repeat (5) drive(1'b0, 0, 1'b1, 32'd3, 32'd4, 64'd13);
    chk("win_xfers", xfer_seen - base, 2);
    chk("win_ready_low", d1_in_ready, 1'b0);
    wait_done("win_done", 20);
    chk("win_err_cnt", d1_err_cnt, 2);

    // n_samples = 0
    drive(1'b1, 0, 1'b0, '0, '0, '0);
    chk("zero_done", d1_done, 1'b1);
    chk("zero_ready", d1_in_ready, 1'b0);
    chk("zero_err_cnt", d1_err_cnt, 0);
    repeat (3) drive(1'b0, 0, 1'b1, 32'd5, 32'd5, 64'd1);
    chk("zero_ready_after", d1_in_ready, 1'b0);

    // restart mid-window
    drive(1'b1, 8, 1'b0, '0, '0, '0);
    repeat (3) drive(1'b0, 0, 1'b1, 32'd10, 32'd10, 64'd90);
    idle(3);
    chk("rs_before_err_cnt", d1_err_cnt, 3);
    drive(1'b1, 2, 1'b1, 32'd10, 32'd10, 64'd90);
    chk("rs_err_cnt", d1_err_cnt, 0);
    chk("rs_ed_sum", d1_ed_sum, 0);
    repeat (2) drive(1'b0, 0, 1'b1, 32'd7, 32'd3, 64'd25);
    wait_done("rs_done", 20);
    chk("rs_err_cnt2", d1_err_cnt, 2);
    chk("rs_ed_sum2", d1_ed_sum, 8);
    chk("rs_ed_max2", d1_ed_max, 4);

    // saturation on the narrow instance
    drive(1'b1, 3, 1'b0, '0, '0, '0);
    repeat (3) drive(1'b0, 0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0);
    wait_done("sat_done", 20);
    chk("sat_d2", d2_sat, 1'b1);
    chk("sat_d2_sum", d2_ed_sum, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("sat_d1", d1_sat, 1'b0);
    chk("sat_d1_sum", d1_ed_sum, 80'h2_FFFF_FFFA_0000_0003);
    chk("sat_d1_max", d1_ed_max, 64'hFFFF_FFFE_0000_0001);

    // reset mid-window
    drive(1'b1, 5, 1'b0, '0, '0, '0);
    repeat (2) drive(1'b0, 0, 1'b1, 32'd10, 32'd10, 64'd90);
    idle(2);
    rst_n = 1'b0;
    #2;
    chk("mrst_busy", d1_busy, 1'b0);
    chk("mrst_err_cnt", d1_err_cnt, 0);
    idle(2);
    rst_n = 1'b1;
    idle(1);

    // randomized windows
    for (int w = 0; w < 25; w++) begin
      drive(1'b1, $urandom_range(1, 10), 1'b0, '0, '0, '0);
      for (int c = 0; c < 200 && !d1_done; c++) begin
        ra = $urandom;
        rb = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
        ex = (2*W)'(ra) * (2*W)'(rb);
        case ($urandom_range(0, 3))
          0:       rp = ex;
          1:       rp = ex + (2*W)'($urandom_range(0, 20));
          2:       rp = ex - (2*W)'($urandom_range(0, 20));
          default: rp = {$urandom, $urandom};
        endcase
        drive($urandom_range(0, 59) == 0, $urandom_range(0, 6),
              $urandom_range(0, 3) != 0, ra, rb, rp);
      end
      chk("rand_done", d1_done, 1'b1);
    end

    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
